// File: rtl/key_pkg.sv
// key_pkg: shared scan codes, key slot indices and enums for the PS/2 step decoder.
package key_pkg;

   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_BAT   = 8'hAA;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ARR_L = 8'h6B;
   localparam logic [7:0] SC_ARR_R = 8'h74;
   localparam logic [7:0] SC_ARR_U = 8'h75;

   localparam int NKEY_MAX = 7;
   localparam int K_A  = 0;
   localparam int K_D  = 1;
   localparam int K_W  = 2;
   localparam int K_SP = 3;
   localparam int K_AL = 4;
   localparam int K_AR = 5;
   localparam int K_AU = 6;

   typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} pfx_state_t;
   typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

endpackage

// File: rtl/key_step_decoder.sv
// key_step_decoder: PS/2 make/break bytes to held-key step levels with last-pressed direction priority.
// Define ARROW_KEYS_EN to map E0 6B/74/75 (arrow keys) onto left/right/jump.
module key_step_decoder
   import key_pkg::*;
#(
   parameter logic [7:0] SC_LEFT  = SC_A,
   parameter logic [7:0] SC_RIGHT = SC_D,
   parameter logic [7:0] SC_JUMP0 = SC_W,
   parameter logic [7:0] SC_JUMP1 = SC_SPACE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       clear,
   output logic       stepleft,
   output logic       stepright,
   output logic       stepjump,
   output logic       kbd_reset_seen
);

`ifdef ARROW_KEYS_EN
   localparam int NK = 7;
`else
   localparam int NK = 4;
`endif

   pfx_state_t    state, state_nxt;
   dir_t          dir, dir_nxt;
   logic [NK-1:0] held, held_nxt, mask;
   logic [NKEY_MAX-1:0] hc, hn;
   logic          ext, brk, bat;
   logic          left_c, right_c, left_n, right_n, jump_n;

   assign ext = state == ST_EXT || state == ST_EXT_BRK;
   assign brk = state == ST_BRK || state == ST_EXT_BRK;

   always_comb begin
      mask = '0;
      if (!ext) begin
         mask[K_A]  = rx_data == SC_LEFT;
         mask[K_D]  = rx_data == SC_RIGHT;
         mask[K_W]  = rx_data == SC_JUMP0;
         mask[K_SP] = rx_data == SC_JUMP1;
      end
`ifdef ARROW_KEYS_EN
      if (ext) begin
         mask[K_AL] = rx_data == SC_ARR_L;
         mask[K_AR] = rx_data == SC_ARR_R;
         mask[K_AU] = rx_data == SC_ARR_U;
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      held_nxt  = held;
      bat       = 1'b0;
      if (clear) begin
         state_nxt = ST_IDLE;
         held_nxt  = '0;
      end else if (rx_valid) begin
         if (rx_data == SC_E0)
            state_nxt = (state == ST_EXT_BRK) ? ST_EXT_BRK : ST_EXT;
         else if (rx_data == SC_F0)
            state_nxt = ext ? ST_EXT_BRK : ST_BRK;
         else begin
            state_nxt = ST_IDLE;
            bat       = state == ST_IDLE && rx_data == SC_BAT;
            held_nxt  = bat ? '0 : brk ? (held & ~mask) : (held | mask);
         end
      end
   end

   // Arrow slots read as zero when the arrow bank is not built.
   assign hc      = NKEY_MAX'(held);
   assign hn      = NKEY_MAX'(held_nxt);
   assign left_c  = hc[K_A] | hc[K_AL];
   assign right_c = hc[K_D] | hc[K_AR];
   assign left_n  = hn[K_A] | hn[K_AL];
   assign right_n = hn[K_D] | hn[K_AR];
   assign jump_n  = hn[K_W] | hn[K_SP] | hn[K_AU];
   assign dir_nxt = clear ? DIR_RIGHT :
                    (left_n & ~left_c) ? DIR_LEFT :
                    (right_n & ~right_c) ? DIR_RIGHT : dir;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         held           <= '0;
         dir            <= DIR_RIGHT;
         stepleft       <= 1'b0;
         stepright      <= 1'b0;
         stepjump       <= 1'b0;
         kbd_reset_seen <= 1'b0;
      end else begin
         state          <= state_nxt;
         held           <= held_nxt;
         dir            <= dir_nxt;
         stepleft       <= left_n & (~right_n | dir_nxt == DIR_LEFT);
         stepright      <= right_n & (~left_n | dir_nxt == DIR_RIGHT);
         stepjump       <= jump_n;
         kbd_reset_seen <= bat;
      end
   end

endmodule

// File: tb/tb_key_step_decoder.sv
// tb_key_step_decoder: directed checks of {stepleft, stepright, stepjump, kbd_reset_seen}.
module tb_key_step_decoder;

`ifdef ARROW_KEYS_EN
   localparam logic ARW = 1'b1;
`else
   localparam logic ARW = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       clear = 1'b0;
   logic       stepleft, stepright, stepjump, kbd_reset_seen;
   int         checks = 0;
   int         errors = 0;

   key_step_decoder dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .clear(clear),
      .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump),
      .kbd_reset_seen(kbd_reset_seen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] exp);
      logic [3:0] obs;
      obs = {stepleft, stepright, stepjump, kbd_reset_seen};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed lrjk=%b expected lrjk=%b", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset", 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_reset", 4'b0000);

      send(8'h23); chk("d_make", 4'b0100);
      send(8'h1C); chk("a_over_d", 4'b1000);
      send(8'hF0); chk("f0_pending", 4'b1000);
      send(8'h1C); chk("a_break", 4'b0100);
      send(8'hF0); send(8'h23); chk("d_break", 4'b0000);

      send(8'h1C); chk("a_make", 4'b1000);
      send(8'h23); chk("d_over_a", 4'b0100);
      for (int i = 0; i < 3; i++) begin
         send(8'h1C); chk("a_typematic", 4'b0100);
      end
      send(8'hF0); send(8'h1C); chk("a_rel_d_held", 4'b0100);
      send(8'hF0); send(8'h23); chk("all_rel", 4'b0000);

      send(8'hE0); chk("e0_pending", 4'b0000);
      send(8'h75); chk("arr_u_make", {2'b00, ARW, 1'b0});
      send(8'hE0); send(8'hF0); chk("e0f0_pending", {2'b00, ARW, 1'b0});
      send(8'h75); chk("arr_u_break", 4'b0000);

      send(8'h1D); chk("w_make", 4'b0010);
      clear = 1'b1; rx_data = 8'h29; rx_valid = 1'b1;
      @(negedge clk);
      clear = 1'b0; rx_valid = 1'b0;
      chk("clear_wins", 4'b0000);

      send(8'hE0);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      send(8'h1C); chk("clear_drops_e0", 4'b1000);
      send(8'hF0); send(8'h1C); chk("a_break2", 4'b0000);

      send(8'hF0); send(8'hE0); send(8'h6B); chk("f0e0_is_make", {ARW, 3'b000});
      send(8'h1D); chk("w_with_arrow", {ARW, 2'b01, 1'b0});
      send(8'hAA); chk("bat_pulse", 4'b0001);
      @(negedge clk);
      chk("bat_one_cycle", 4'b0000);
      send(8'h1C); chk("idle_after_bat", 4'b1000);
      send(8'hF0); send(8'h1C); chk("a_break3", 4'b0000);

      send(8'hE0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("reset_mid_seq", 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);
      send(8'h1C); chk("no_stale_ext", 4'b1000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
